// File: rtl/rv_pkg.sv
// Shared write-back types and sizes for the register-file write path.
package rv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    // One queued register write; live drops when a younger ALU write supersedes it
    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // Which producer owns the write port this cycle
    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_ALU   = 2'd1,
        GNT_MDU   = 2'd2,
        GNT_FORCE = 2'd3
    } grant_e;

    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        return NUM_REGS'(1) << rd;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending MDU writes with in-place kill and pending-register mask.
module wb_fifo
    import rv_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  wb_req_t               i_push_req,
    input  logic                  i_pop,
    input  logic                  i_kill_en,
    input  logic [REG_ADDR_W-1:0] i_kill_rd,
    output wb_req_t               o_head_c,
    output logic                  o_empty,
    output logic                  o_ready,
    output logic [CNT_W-1:0]      o_count,
    output logic [NUM_REGS-1:0]   o_pending_mask
);

    wb_req_t               r_mem [DEPTH];
    wb_req_t               w_mem_nxt [DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_count_nxt;
    logic                  r_empty;
    logic                  r_ready;
    logic [NUM_REGS-1:0]   r_mask;
    logic [NUM_REGS-1:0]   w_mask_nxt;

    // Next storage image: kill matching entries, retire the popped slot, insert the push
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_mem_nxt[i] = r_mem[i];
            if (i_kill_en && (r_mem[i].rd == i_kill_rd)) begin
                w_mem_nxt[i].live = 1'b0;
            end
        end
        if (i_pop) begin
            w_mem_nxt[r_rptr].live = 1'b0;
        end
        if (i_push) begin
            w_mem_nxt[r_wptr]      = i_push_req;
            w_mem_nxt[r_wptr].live = i_push_req.live &&
                                     !(i_kill_en && (i_push_req.rd == i_kill_rd));
        end
    end

    // Occupancy and pending mask as they will stand after this edge
    always_comb begin
        w_count_nxt = r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        w_mask_nxt  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_mem_nxt[i].live) begin
                w_mask_nxt = w_mask_nxt | rd_onehot(w_mem_nxt[i].rd);
            end
        end
    end

    // Storage, pointers and registered status
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_ready <= 1'b0;
            r_mask  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= w_mem_nxt[i];
            end
            if (i_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_ready <= (w_count_nxt != CNT_W'(DEPTH));
            r_mask  <= w_mask_nxt;
        end
    end

    assign o_head_c       = r_mem[r_rptr];
    assign o_empty        = r_empty;
    assign o_ready        = r_ready;
    assign o_count        = r_count;
    assign o_pending_mask = r_mask;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges ALU and MDU write-backs onto the single register-file write port.
module regfile_write_arbiter
    import rv_pkg::*;
#(
    parameter  int unsigned DEPTH        = 4,
    parameter  int unsigned STARVE_LIMIT = 8,
    localparam int unsigned CNT_W        = $clog2(DEPTH) + 1,
    localparam int unsigned STARVE_W     = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_stall,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] mdu_rd,
    input  logic [XLEN-1:0]       mdu_data,
    output logic                  WE3,
    output logic [REG_ADDR_W-1:0] AD3,
    output logic [XLEN-1:0]       WD3,
    output logic [NUM_REGS-1:0]   pending_mask,
    output logic [CNT_W-1:0]      fifo_count
);

    wb_req_t               w_push_req;
    wb_req_t               w_head;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_kill_en;
    logic                  w_fifo_empty;
    logic                  w_fifo_ready;
    logic                  w_force;
    grant_e                w_grant;

    logic                  r_we3;
    logic [REG_ADDR_W-1:0] r_ad3;
    logic [XLEN-1:0]       r_wd3;
    logic [STARVE_W-1:0]   r_starve;
    logic                  w_we_nxt;
    logic [REG_ADDR_W-1:0] w_ad_nxt;
    logic [XLEN-1:0]       w_wd_nxt;
    logic [STARVE_W-1:0]   w_starve_nxt;

    // Writes to x0 are never live, so they never show up as pending
    assign w_push_req = {(mdu_rd != '0), mdu_rd, mdu_data};
    assign w_push     = mdu_valid && w_fifo_ready;
    assign w_force    = (r_starve == STARVE_W'(STARVE_LIMIT)) && !w_fifo_empty;
    assign alu_stall  = w_force && alu_valid;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .i_push         (w_push),
        .i_push_req     (w_push_req),
        .i_pop          (w_pop),
        .i_kill_en      (w_kill_en),
        .i_kill_rd      (alu_rd),
        .o_head_c       (w_head),
        .o_empty        (w_fifo_empty),
        .o_ready        (w_fifo_ready),
        .o_count        (fifo_count),
        .o_pending_mask (pending_mask)
    );

    // Priority pick: starvation drain, then ALU, then queued MDU
    always_comb begin
        w_grant = GNT_IDLE;
        if (w_force) begin
            w_grant = GNT_FORCE;
        end else if (alu_valid) begin
            w_grant = GNT_ALU;
        end else if (!w_fifo_empty) begin
            w_grant = GNT_MDU;
        end
    end

    // Next write-port contents, FIFO control and starvation count for the grant
    always_comb begin
        w_we_nxt     = 1'b0;
        w_ad_nxt     = r_ad3;
        w_wd_nxt     = r_wd3;
        w_starve_nxt = r_starve;
        w_pop        = 1'b0;
        w_kill_en    = 1'b0;
        case (w_grant)
            GNT_FORCE, GNT_MDU: begin
                w_pop        = 1'b1;
                w_we_nxt     = w_head.live && (w_head.rd != '0);
                w_ad_nxt     = w_head.rd;
                w_wd_nxt     = w_head.data;
                w_starve_nxt = '0;
            end
            GNT_ALU: begin
                w_we_nxt  = (alu_rd != '0);
                w_ad_nxt  = alu_rd;
                w_wd_nxt  = alu_data;
                w_kill_en = (alu_rd != '0);
                if (w_fifo_empty) begin
                    w_starve_nxt = '0;
                end else if (r_starve != STARVE_W'(STARVE_LIMIT)) begin
                    w_starve_nxt = r_starve + STARVE_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Registered write port and starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we3    <= 1'b0;
            r_ad3    <= '0;
            r_wd3    <= '0;
            r_starve <= '0;
        end else begin
            r_we3    <= w_we_nxt;
            r_ad3    <= w_ad_nxt;
            r_wd3    <= w_wd_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    assign WE3       = r_we3;
    assign AD3       = r_ad3;
    assign WD3       = r_wd3;
    assign mdu_ready = w_fifo_ready;

endmodule
